serial_addsub_ctrl: RTL and testbench

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/serial_addsub_ctrl_if.sv | 39 +++
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 114 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle for serial_addsub_ctrl; ovf_o exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    // Handshake: a request is accepted on a rising edge where start_i=1 and ready_o=1;
    // a_i/b_i/sub_i are sampled only on that edge, and done_o pulses once when the result is valid.
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_o;
`endif

    modport master (
        output start_i, a_i, b_i, sub_i,
        input  ready_o, busy_o, done_o, result_o, carry_o
`ifdef SERIAL_ADDSUB_OVF_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  start_i, a_i, b_i, sub_i,
        output ready_o, busy_o, done_o, result_o, carry_o
`ifdef SERIAL_ADDSUB_OVF_EN
        , output ovf_o
`endif
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder shared by every bit position of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through a single full adder.
// Optional signed-overflow flag ovf_o is built when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_addsub_ctrl_if.slave  bus,
    output state_t               state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               cin_reg;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   idx;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               fa_sum;
    logic               fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q;
`endif

    assign idx = count[IDX_W-1:0];

    full_adder u_fa (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (cin_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Subtraction is A + ~B + 1: B is inverted at capture and the carry register seeded with 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            count    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            cin_reg  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        a_reg   <= bus.a_i;
                        b_reg   <= bus.b_i ^ {WIDTH{bus.sub_i}};
                        cin_reg <= bus.sub_i;
                        count   <= '0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    result_q[idx] <= fa_sum;
                    cin_reg       <= fa_cout;
                    count         <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        carry_q <= fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // cin_reg here is the carry into the MSB position.
                        ovf_q   <= cin_reg ^ fa_cout;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.carry_o  = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.ovf_o    = ovf_q;
`endif
    assign state_dbg    = state;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: directed and random operations against an arithmetic model.
// Overflow checks are compiled in when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_ctrl;
  import serial_addsub_pkg::*;

  localparam int WIDTH = 8;
  localparam int EW    = 32 + 2 + WIDTH;  // {accept cycle, ovf, carry, result}

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_acc    = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views of the operands.
  function automatic logic [WIDTH+1:0] model(input longint a, input longint b, input bit sub);
    longint lim, half, s, sa, sb, sr;
    logic c, o;
    logic [WIDTH-1:0] r;
    lim  = longint'(1) << WIDTH;
    half = lim / 2;
    if (!sub) begin
      s = a + b;
      c = (s >= lim);
    end else begin
      s = a - b + lim;
      c = (a >= b);
    end
    r  = WIDTH'(s % lim);
    sa = (a >= half) ? a - lim : a;
    sb = (b >= half) ? b - lim : b;
    sr = sub ? sa - sb : sa + sb;
    o  = (sr >= half) || (sr < -half);
    return {o, c, r};
  endfunction

  // Monitor: every done_o pulse must match the oldest pending operation, including its timing.
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done_o high at cycle %0d with no operation pending", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        // accept at edge N -> done_o high in the cycle after edge N+WIDTH
        check("done_latency", 64'(cyc), 64'(mon_e[EW-1 -: 32] + WIDTH));
        check("result", 64'(bus.result_o), 64'(mon_e[WIDTH-1:0]));
        check("carry", 64'(bus.carry_o), 64'(mon_e[WIDTH]));
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", 64'(bus.ovf_o), 64'(mon_e[WIDTH+1]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    while (!bus.ready_o && t < 4 * WIDTH + 8) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready_o) timeout_fail("wait_ready");
  endtask

  task automatic scramble_inputs();
    bus.a_i   = WIDTH'($urandom);
    bus.b_i   = WIDTH'($urandom);
    bus.sub_i = 1'($urandom);
  endtask

  // One operation; noise=1 also pulses start_i with fresh operands while the block is busy.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sub,
                       input logic [WIDTH+1:0] e, input bit noise);
    int unsigned acc;
    @(negedge clk);
    wait_ready();
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.sub_i   = sub;
    acc = cyc + 1;
    exp_q.push_back({acc, e});
    n_acc++;
    @(negedge clk);
    bus.start_i = 1'b0;
    scramble_inputs();
    if (noise) begin
      repeat ($urandom_range(0, WIDTH - 3)) @(negedge clk);
      if (!bus.ready_o) begin
        bus.start_i = 1'b1;
        scramble_inputs();
        @(negedge clk);
        bus.start_i = 1'b0;
        scramble_inputs();
      end
    end
    wait_ready();
    @(negedge clk);
    check("hold_result", 64'(bus.result_o), 64'(e[WIDTH-1:0]));
    check("hold_carry", 64'(bus.carry_o), 64'(e[WIDTH]));
  endtask

  // start_i held high across two operations: the second is taken in the IDLE cycle after DONE.
  task automatic back_to_back(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input bit s1,
                              input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2, input bit s2);
    int unsigned acc1, acc2;
    int t;
    @(negedge clk);
    wait_ready();
    bus.start_i = 1'b1;
    bus.a_i = a1; bus.b_i = b1; bus.sub_i = s1;
    acc1 = cyc + 1;
    exp_q.push_back({acc1, model(longint'(a1), longint'(b1), s1)});
    n_acc++;
    @(negedge clk);
    bus.a_i = a2; bus.b_i = b2; bus.sub_i = s2;
    acc2 = acc1 + WIDTH + 2;
    exp_q.push_back({acc2, model(longint'(a2), longint'(b2), s2)});
    n_acc++;
    t = 0;
    while (cyc != acc2 && t < 4 * WIDTH) begin
      @(negedge clk);
      t++;
    end
    if (cyc != acc2) timeout_fail("b2b_wait");
    bus.start_i = 1'b0;
    scramble_inputs();
    wait_ready();
  endtask

  // Reset on the 4th RUN cycle must abort with no done_o pulse.
  task automatic reset_mid_run();
    int unsigned acc;
    int t;
    @(negedge clk);
    wait_ready();
    bus.start_i = 1'b1;
    bus.a_i = 8'd10; bus.b_i = 8'd20; bus.sub_i = 1'b0;
    acc = cyc + 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    t = 0;
    while (cyc != acc + 3 && t < 2 * WIDTH) begin
      @(negedge clk);
      t++;
    end
    if (cyc != acc + 3) timeout_fail("rst_wait");
    check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_carry", 64'(bus.carry_o), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [WIDTH-1:0] ra, rb;
  bit               rs;

  initial begin
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.sub_i   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd1);
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    check("reset_done", 64'(bus.done_o), 64'd0);
    check("reset_result", 64'(bus.result_o), 64'd0);
    check("reset_carry", 64'(bus.carry_o), 64'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("reset_ovf", 64'(bus.ovf_o), 64'd0);
`endif
    rst = 1'b0;

    // directed: {ovf, carry, result}
    do_op(8'd25,  8'd17,  1'b0, {1'b0, 1'b0, 8'd42},  1'b0);
    do_op(8'd200, 8'd100, 1'b0, {1'b0, 1'b1, 8'd44},  1'b0);
    do_op(8'd5,   8'd7,   1'b1, {1'b0, 1'b0, 8'd254}, 1'b0);
    do_op(8'd7,   8'd5,   1'b1, {1'b0, 1'b1, 8'd2},   1'b0);
    do_op(8'd99,  8'd33,  1'b0, {1'b1, 1'b0, 8'd132}, 1'b1);
    do_op(8'd0,   8'd0,   1'b1, {1'b0, 1'b1, 8'd0},   1'b0);
    do_op(8'd255, 8'd255, 1'b0, {1'b0, 1'b1, 8'd254}, 1'b0);

    reset_mid_run();
    do_op(8'd3, 8'd4, 1'b0, {1'b0, 1'b0, 8'd7}, 1'b0);

`ifdef SERIAL_ADDSUB_OVF_EN
    do_op(8'd127, 8'd1,  1'b0, {1'b1, 1'b0, 8'd128}, 1'b0);
    do_op(8'd100, 8'd20, 1'b0, {1'b0, 1'b0, 8'd120}, 1'b0);
    do_op(8'd128, 8'd1,  1'b1, {1'b1, 1'b1, 8'd127}, 1'b0);
`endif

    back_to_back(8'd25, 8'd17, 1'b0, 8'd5, 8'd7, 1'b1);
    back_to_back(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, model(longint'(ra), longint'(rb), rs), 1'($urandom_range(0, 1)));
    end

    repeat (WIDTH + 4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
